// File: rtl/instr_fetch_ctrl_pkg.sv
// instr_fetch_ctrl_pkg: shared state encoding and default geometry for the fetch controller
package instr_fetch_ctrl_pkg;
  localparam int DEF_WORD_LEN = 16;
  localparam int DEF_CELL_W = 4;
  typedef enum logic [1:0] {
    FETCH_ST_LOAD  = 2'd0,
    FETCH_ST_FETCH = 2'd1,
    FETCH_ST_HOLD  = 2'd2
  } fetch_st_e;
endpackage

// File: rtl/instr_fetch_ctrl_nibble_assembler.sv
// nibble_assembler: shifts cells in at the LSB end; only the low WORD_LEN-CELL_W bits need storing
module nibble_assembler #(
  parameter int WORD_LEN = 16,
  parameter int CELL_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic [CELL_W-1:0]   din,
  output logic [WORD_LEN-1:0] word
);
  logic [WORD_LEN-CELL_W-1:0] acc_q, acc_d;
  always_comb begin
    word  = {acc_q, din};
    acc_d = clr ? '0 : en ? word[WORD_LEN-CELL_W-1:0] : acc_q;
  end
  always_ff @(posedge clk) acc_q <= rst ? '0 : acc_d;
endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: loads the program image into nibble memory, then fetches and assembles instructions for IF/ID
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int WORD_LEN = DEF_WORD_LEN,
  parameter int CELL_W = DEF_CELL_W,
  parameter int MEM_SIZE = 256,
  parameter int RESET_PC = 0,
  localparam int ADDR_W = $clog2(MEM_SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_valid,
  input  logic [CELL_W-1:0]   ld_data,
  input  logic                ld_last,
  output logic                ld_ready,
  input  logic                ld_req,
  input  logic                stall,
  input  logic                br_taken,
  input  logic [WORD_LEN-1:0] br_target,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [CELL_W-1:0]   mem_wdata,
  input  logic [CELL_W-1:0]   mem_rdata,
  output logic [WORD_LEN-1:0] instr,
  output logic [WORD_LEN-1:0] pc,
  output logic                instr_valid
);
  localparam int CELLS_PER_WORD = WORD_LEN / CELL_W;
  localparam int K_W = $clog2(CELLS_PER_WORD);
  fetch_st_e state_q, state_d;
  logic [ADDR_W-1:0] ld_ptr_q, ld_ptr_d;
  logic [WORD_LEN-1:0] fetch_pc_q, fetch_pc_d, instr_q, instr_d, pc_q, pc_d;
  logic [K_W-1:0] k_q, k_d;
  logic instr_valid_q, instr_valid_d;
  logic asm_clr, asm_en;
  logic [WORD_LEN-1:0] asm_word;
  nibble_assembler #(.WORD_LEN(WORD_LEN), .CELL_W(CELL_W)) u_asm (
    .clk(clk), .rst(rst), .clr(asm_clr), .en(asm_en), .din(mem_rdata), .word(asm_word)
  );
  always_comb begin
    state_d = state_q;
    ld_ptr_d = ld_ptr_q;
    fetch_pc_d = fetch_pc_q;
    k_d = k_q;
    instr_d = instr_q;
    pc_d = pc_q;
    instr_valid_d = instr_valid_q;
    asm_clr = 1'b0;
    asm_en = 1'b0;
    ld_ready = state_q == FETCH_ST_LOAD;
    mem_we = ld_ready & ld_valid;
    mem_wdata = ld_data;
    mem_addr = ld_ready ? ld_ptr_q : ADDR_W'(fetch_pc_q + WORD_LEN'(k_q));
    if (ld_ready) begin
      if (ld_valid) ld_ptr_d = ld_ptr_q == ADDR_W'(MEM_SIZE - 1) ? '0 : ld_ptr_q + 1'b1;
      if (ld_valid && ld_last) begin
        state_d = FETCH_ST_FETCH;
        fetch_pc_d = WORD_LEN'(RESET_PC);
        k_d = '0;
        asm_clr = 1'b1;
      end
    end else if (ld_req) begin
      state_d = FETCH_ST_LOAD;
      ld_ptr_d = '0;
      instr_valid_d = 1'b0;
      asm_clr = 1'b1;
    end else if (br_taken) begin
      state_d = FETCH_ST_FETCH;
      fetch_pc_d = br_target;
      k_d = '0;
      instr_valid_d = 1'b0;
      asm_clr = 1'b1;
    end else if (state_q == FETCH_ST_FETCH) begin
      asm_en = 1'b1;
      k_d = k_q + 1'b1;
      if (k_q == K_W'(CELLS_PER_WORD - 1)) begin
        state_d = FETCH_ST_HOLD;
        instr_d = asm_word;
        pc_d = fetch_pc_q;
        instr_valid_d = 1'b1;
      end
    end else if (!stall) begin
      state_d = FETCH_ST_FETCH;
      fetch_pc_d = fetch_pc_q + WORD_LEN'(CELLS_PER_WORD);
      k_d = '0;
      instr_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH_ST_LOAD;
      ld_ptr_q <= '0;
      fetch_pc_q <= WORD_LEN'(RESET_PC);
      k_q <= '0;
      instr_q <= '0;
      pc_q <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ld_ptr_q <= ld_ptr_d;
      fetch_pc_q <= fetch_pc_d;
      k_q <= k_d;
      instr_q <= instr_d;
      pc_q <= pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end
  assign instr = instr_q;
  assign pc = pc_q;
  assign instr_valid = instr_valid_q;
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: randomized scoreboard bench; the model predicts each word from the loaded image
module tb_instr_fetch_ctrl;
  localparam int CELLS_PER_WORD = 4;
  logic clk = 0, rst = 1;
  logic ld_valid = 0, ld_last = 0, ld_req = 0, stall = 0, br_taken = 0, ld_ready, mem_we, instr_valid;
  logic [3:0] ld_data = 0, mem_wdata, mem_rdata;
  logic [15:0] br_target = 0, instr, pc;
  logic [7:0] mem_addr;
  logic [3:0] mem [256];
  logic [3:0] ref_mem [256];
  logic [3:0] img [$];
  typedef struct packed {logic [15:0] pc; logic [15:0] instr;} xact_t;
  xact_t exp_q [$];
  xact_t cur;
  logic in_hold = 0;
  int vectors = 0, errors = 0, model_pc = 0;

  instr_fetch_ctrl dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_req(ld_req), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .instr(instr), .pc(pc), .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] word_at(input int p);
    return {ref_mem[p % 256], ref_mem[(p + 1) % 256], ref_mem[(p + 2) % 256], ref_mem[(p + 3) % 256]};
  endfunction

  always @(negedge clk) begin
    if (rst) in_hold = 0;
    else begin
      if (instr_valid && !in_hold) begin
        in_hold = 1;
        if (exp_q.size() == 0) begin
          cur = '0;
          vectors++;
          errors++;
          $display("FAIL unexpected_valid: got pc=%0h instr=%0h, expected no word", pc, instr);
        end else begin
          cur = exp_q.pop_front();
          chk("word", {pc, instr}, cur);
        end
      end else if (instr_valid) chk("hold_stable", {pc, instr}, cur);
      if (!instr_valid) in_hold = 0;
      if (ld_ready) chk("valid_in_load", {31'd0, instr_valid}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load();
    int ptr = 0;
    foreach (img[i]) begin
      if ($urandom_range(0, 3) == 0) begin
        ld_valid = 0;
        #0 chk("idle_no_write", {31'd0, mem_we}, 32'd0);
        tick();
      end
      ld_valid = 1;
      ld_data = img[i];
      ld_last = i == img.size() - 1;
      #0 chk("load_ready_we", {30'd0, ld_ready, mem_we}, 32'd3);
      tick();
      ref_mem[ptr] = img[i];
      ptr = (ptr + 1) % 256;
    end
    ld_valid = 0;
    ld_last = 0;
    model_pc = 0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    chk("fetch_latency", n, CELLS_PER_WORD);
  endtask

  task automatic expect_word(input int ns);
    exp_q.push_back({16'(model_pc), word_at(model_pc)});
    stall = ns > 0;
    wait_valid();
    repeat (ns) tick();
    stall = 0;
    tick();
    chk("accept_clears_valid", {31'd0, instr_valid}, 32'd0);
    model_pc = (model_pc + 4) % 65536;
  endtask

  task automatic branch(input int at_k, input int tgt);
    repeat (at_k) begin
      stall = 1'($urandom_range(0, 1));
      tick();
    end
    br_taken = 1;
    br_target = 16'(tgt);
    tick();
    br_taken = 0;
    stall = 0;
    model_pc = tgt;
  endtask

  task automatic branch_in_hold(input int tgt);
    exp_q.push_back({16'(model_pc), word_at(model_pc)});
    stall = 1;
    wait_valid();
    br_taken = 1;
    br_target = 16'(tgt);
    tick();
    br_taken = 0;
    stall = 0;
    chk("branch_hold_drops_valid", {31'd0, instr_valid}, 32'd0);
    model_pc = tgt;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 0;
      ref_mem[i] = 0;
    end
    repeat (2) tick();
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr_pc", {pc, instr}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    rst = 0;
    img = '{4'h3, 4'h1, 4'h0, 4'hF, 4'h3, 4'h1, 4'h0, 4'h2, 4'h9, 4'h1, 4'h2, 4'h0};
    load();
    repeat (3) expect_word(0);
    branch(0, 0);
    expect_word(3);
    branch(0, 4);
    branch(2, 8);
    expect_word(0);
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 2))
        0: expect_word(int'($urandom_range(0, 3)));
        1: branch(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)));
        default: branch_in_hold(int'($urandom_range(0, 65535)));
      endcase
    end
    ld_req = 1;
    tick();
    ld_req = 0;
    chk("ld_req_fetch_to_load", {31'd0, ld_ready}, 32'd1);
    img = {};
    for (int i = 0; i < 258; i++) img.push_back(4'($urandom));
    img[254] = 4'hA;
    img[255] = 4'hB;
    img[256] = 4'h3;
    img[257] = 4'h1;
    load();
    branch(0, 254);
    expect_word(0);
    branch(0, 16);
    repeat (2) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("rst_mid_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("rst_mid_valid", {31'd0, instr_valid}, 32'd0);
    img = '{4'h5};
    load();
    expect_word(0);
    exp_q.push_back({16'(model_pc), word_at(model_pc)});
    stall = 1;
    wait_valid();
    ld_req = 1;
    tick();
    ld_req = 0;
    stall = 0;
    chk("ld_req_hold_ready", {31'd0, ld_ready}, 32'd1);
    chk("ld_req_hold_valid", {31'd0, instr_valid}, 32'd0);
    img = '{4'h7, 4'h1, 4'h7, 4'h0};
    load();
    expect_word(0);
    ld_req = 1;
    tick();
    ld_req = 0;
    repeat (6) tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
